// File: rtl/lynx_tape_pkg.sv
// Shared tape-path definitions: playback state encoding and counter widths.
package lynx_tape_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } tape_state_t;

    localparam int FILT_CNT_W = 8;
    localparam int TMO_W      = 24;

endpackage

// File: rtl/tape_ear_conditioner_glitch_filter.sv
// glitch_filter: persistence filter on a synchronized level. The output level
// only follows d once d has disagreed with it for FILT_LEN consecutive cycles;
// q_edge is a one-cycle pulse registered together with each change of q.
module glitch_filter
    import lynx_tape_pkg::*;
#(
    parameter int FILT_LEN = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic q_edge
);

    localparam logic [FILT_CNT_W-1:0] LP_LAST = FILT_CNT_W'(FILT_LEN - 1);
    localparam logic [FILT_CNT_W-1:0] LP_ONE  = FILT_CNT_W'(1);

    logic [FILT_CNT_W-1:0] r_cnt;
    logic                  r_q;
    logic                  r_edge;

    // Count consecutive disagreeing cycles; flip the level when the run completes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_edge <= 1'b0;
            if (d != r_q) begin
                if (r_cnt == LP_LAST) begin
                    r_q    <= ~r_q;
                    r_cnt  <= '0;
                    r_edge <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + LP_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign q      = r_q;
    assign q_edge = r_edge;

endmodule

// File: rtl/tape_ear_conditioner.sv
// tape_ear_conditioner: synchronizes the tape ADC comparator bit, debounces it,
// and gates it onto the ear input only once playback has locked (RUN).
// Optional build macro TAPE_EAR_PERIOD_EN adds a rising-edge period measurement.
module tape_ear_conditioner
    import lynx_tape_pkg::*;
#(
    parameter int               FILT_LEN     = 16,
    parameter logic [TMO_W-1:0] IDLE_TIMEOUT = 24'd4000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        adc_bit,
    input  logic        adc_act,
    output logic        ear,
    output logic        tape_led,
`ifdef TAPE_EAR_PERIOD_EN
    output logic [15:0] period,
    output logic        period_vld,
`endif
    output logic        edge_stb
);

    localparam logic [TMO_W-1:0] LP_TMO_ONE = TMO_W'(1);

    logic        r_bit_s1, r_bit_s2;
    logic        r_act_s1, r_act_s2;
    tape_state_t r_state;
    tape_state_t w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic        r_ear;
    logic        w_q;
    logic        w_edge;

    // Two-flop synchronizers for both asynchronous ADC signals.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bit_s1 <= 1'b0;
            r_bit_s2 <= 1'b0;
            r_act_s1 <= 1'b0;
            r_act_s2 <= 1'b0;
        end else begin
            r_bit_s1 <= adc_bit;
            r_bit_s2 <= r_bit_s1;
            r_act_s1 <= adc_act;
            r_act_s2 <= r_act_s1;
        end
    end

    glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (r_bit_s2),
        .q       (w_q),
        .q_edge  (w_edge)
    );

    // Saturating cycles-since-last-edge counter, runs in every state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tmo <= '0;
        end else if (w_edge) begin
            r_tmo <= '0;
        end else if (r_tmo != '1) begin
            r_tmo <= r_tmo + LP_TMO_ONE;
        end
    end

    // Next state: loss of ADC activity wins, then edges, then timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (!r_act_s2) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = SYNC;
                SYNC:    if (w_edge) w_state_nxt = RUN;
                RUN:     if (!w_edge && (r_tmo == IDLE_TIMEOUT)) w_state_nxt = SYNC;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register and ear output; ear follows the filtered level only in RUN.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_ear   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ear   <= (w_state_nxt == RUN) ? w_q : 1'b0;
        end
    end

    assign ear      = r_ear;
    assign tape_led = (r_state == RUN);
    assign edge_stb = w_edge && (r_state != IDLE);

`ifdef TAPE_EAR_PERIOD_EN
    logic [15:0] r_per_cnt;
    logic [15:0] r_period;
    logic        r_period_vld;
    logic        r_per_arm;
    logic        w_rise;

    assign w_rise = w_edge && w_q;

    // Measure cycles between rising filtered edges; the first rise only arms.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_per_cnt    <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_per_arm    <= 1'b0;
        end else begin
            r_period_vld <= 1'b0;
            if (w_rise) begin
                r_per_cnt <= 16'd1;
            end else if (r_per_cnt != 16'hFFFF) begin
                r_per_cnt <= r_per_cnt + 16'd1;
            end
            if (r_state == IDLE) begin
                r_per_arm <= 1'b0;
            end else if (w_rise) begin
                r_per_arm <= 1'b1;
            end
            if (w_rise && r_per_arm && (r_state == RUN)) begin
                r_period     <= r_per_cnt;
                r_period_vld <= 1'b1;
            end
        end
    end

    assign period     = r_period;
    assign period_vld = r_period_vld;
`endif

endmodule
